// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-issue instruction queue between fetch and dual decode
//
// Purpose: circular buffer of {inst, pc} entries. Fetch pushes up to two
// instructions per cycle and decode pops up to two per cycle. The two oldest
// entries are presented in program order as slot 0 and slot 1. A flush
// empties the queue in one cycle.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 discard all entries (redirect/mispredict)
//   in_valid[1:0]         fetch slot valid; bit 1 used only with bit 0
//   in_inst0/1, in_pc0/1  fetched instructions and PCs, slot 0 older
//   in_ready              queue can accept two entries this cycle
//   out_valid[1:0]        at least one / at least two entries held
//   out_inst0/1, out_pc0/1 oldest and second-oldest entries, zero when invalid
//   out_take[1:0]         decode pops; bit 1 used only with bit 0
//   count                 current occupancy
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [WIDTH-1:0]         in_inst0,
  input  logic [WIDTH-1:0]         in_inst1,
  input  logic [WIDTH-1:0]         in_pc0,
  input  logic [WIDTH-1:0]         in_pc1,
  output logic                     in_ready,
  output logic [1:0]               out_valid,
  output logic [WIDTH-1:0]         out_inst0,
  output logic [WIDTH-1:0]         out_inst1,
  output logic [WIDTH-1:0]         out_pc0,
  output logic [WIDTH-1:0]         out_pc1,
  input  logic [1:0]               out_take,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] inst_q [DEPTH];
  logic [WIDTH-1:0] pc_q   [DEPTH];

  logic [1:0]       enq_n;
  logic [1:0]       deq_n;
  logic [PW-1:0]    head_p1;
  logic [PW-1:0]    tail_p1;

  // Pointers are exactly PW bits wide, so +1 wraps modulo DEPTH for free.
  assign head_p1 = head_q + 1'b1;
  assign tail_p1 = tail_q + 1'b1;

  always_comb begin
    // Ready and valid come from registered occupancy only, so a same-cycle
    // dequeue never raises in_ready and no input reaches an output.
    in_ready     = (count_q <= CW'(DEPTH - 2));
    out_valid[0] = (count_q != '0);
    out_valid[1] = (count_q > CW'(1));

    enq_n = 2'd0;
    if (in_ready && in_valid[0]) begin
      enq_n = in_valid[1] ? 2'd2 : 2'd1;
    end

    deq_n = 2'd0;
    if (out_take[0] && out_valid[0]) begin
      deq_n = (out_take[1] && out_valid[1]) ? 2'd2 : 2'd1;
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(deq_n);
      tail_d  = tail_q + PW'(enq_n);
      count_d = count_q + CW'(enq_n) - CW'(deq_n);
    end

    out_inst0 = out_valid[0] ? inst_q[head_q]  : '0;
    out_pc0   = out_valid[0] ? pc_q[head_q]    : '0;
    out_inst1 = out_valid[1] ? inst_q[head_p1] : '0;
    out_pc1   = out_valid[1] ? pc_q[head_p1]   : '0;

    count = count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // A flushed enqueue is dropped; stale contents stay but are gated off.
      if (!flush) begin
        if (enq_n != 2'd0) begin
          inst_q[tail_q] <= in_inst0;
          pc_q[tail_q]   <= in_pc0;
        end
        if (enq_n == 2'd2) begin
          inst_q[tail_p1] <= in_inst1;
          pc_q[tail_p1]   <= in_pc1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - self-checking bench for inst_queue with a queue-based reference model
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [1:0]       in_valid;
  logic [WIDTH-1:0] in_inst0, in_inst1, in_pc0, in_pc1;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [WIDTH-1:0] out_inst0, out_inst1, out_pc0, out_pc1;
  logic [1:0]       out_take;
  logic [3:0]       count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain FIFO of {inst, pc}.
  logic [63:0] mq[$];

  inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_inst0  (in_inst0),
    .in_inst1  (in_inst1),
    .in_pc0    (in_pc0),
    .in_pc1    (in_pc1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_inst0 (out_inst0),
    .out_inst1 (out_inst1),
    .out_pc0   (out_pc0),
    .out_pc1   (out_pc1),
    .out_take  (out_take),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    int sz;
    logic [63:0] e0, e1;
    sz = mq.size();
    e0 = (sz >= 1) ? mq[0] : 64'd0;
    e1 = (sz >= 2) ? mq[1] : 64'd0;
    check("m_count",     64'(count), 64'(sz));
    check("m_in_ready",  64'(in_ready), 64'(sz <= DEPTH - 2));
    check("m_out_valid", 64'(out_valid), 64'({sz >= 2, sz >= 1}));
    check("m_out_inst0", 64'(out_inst0), 64'(e0[63:32]));
    check("m_out_pc0",   64'(out_pc0),   64'(e0[31:0]));
    check("m_out_inst1", 64'(out_inst1), 64'(e1[63:32]));
    check("m_out_pc1",   64'(out_pc1),   64'(e1[31:0]));
  endtask

  // One clock cycle: compare mid-cycle, then apply the sampled inputs to the model.
  task automatic cyc();
    int sz, deq;
    bit rdy;
    #3;
    model_compare();
    @(posedge clk);
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      sz  = mq.size();
      rdy = (sz <= DEPTH - 2);
      deq = 0;
      if (out_take[0] && sz >= 1) deq = (out_take[1] && sz >= 2) ? 2 : 1;
      for (int i = 0; i < deq; i++) void'(mq.pop_front());
      if (rdy && in_valid[0]) begin
        mq.push_back({in_inst0, in_pc0});
        if (in_valid[1]) mq.push_back({in_inst1, in_pc1});
      end
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] t, input logic [31:0] pc);
    in_valid = v;
    out_take = t;
    in_pc0   = pc;
    in_pc1   = pc + 32'd4;
    in_inst0 = 32'hA000_0000 ^ pc;
    in_inst1 = 32'hB000_0000 ^ (pc + 32'd4);
  endtask

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0; flush = 1'b0;
    drive(2'b00, 2'b00, 32'd0);
    @(posedge clk); #1;
    cyc();
    rst_n = 1'b1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);

    // First pair with literal instructions.
    in_valid = 2'b11; out_take = 2'b00;
    in_inst0 = 32'h2001_0005; in_pc0 = 32'h100;
    in_inst1 = 32'h0022_1820; in_pc1 = 32'h104;
    cyc();
    check("p1_valid", 64'(out_valid), 64'd3);
    check("p1_inst0", 64'(out_inst0), 64'h2001_0005);
    check("p1_pc1",   64'(out_pc1),   64'h104);
    check("p1_count", 64'(count),     64'd2);

    // Fill to full with three more pairs.
    for (int k = 1; k < 4; k++) begin
      drive(2'b11, 2'b00, 32'h100 + 32'(8 * k));
      cyc();
    end
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(in_ready), 64'd0);
    // Fifth pair held while not ready must not be written.
    drive(2'b11, 2'b00, 32'h120);
    cyc(); cyc();
    check("held_count", 64'(count), 64'd8);
    drive(2'b00, 2'b11, 32'h0);
    for (int k = 0; k < 4; k++) begin
      check("drain_pc0", 64'(out_pc0), 64'(32'h100 + 32'(8 * k)));
      cyc();
    end
    check("drain_count", 64'(count), 64'd0);

    // Fill to 6, then sustained push2/take2 with wrapping pointers.
    pc = 32'h200;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 2'b00, pc); pc += 32'd8; cyc();
    end
    for (int k = 0; k < 20; k++) begin
      drive(2'b11, 2'b11, pc); pc += 32'd8; cyc();
      check("ss_count", 64'(count), 64'd6);
      check("ss_pc0",   64'(out_pc0), 64'(32'h200 + 32'(8 * (k + 1))));
      check("ss_step",  64'(out_pc1 - out_pc0), 64'd4);
    end

    // Down to 5, then flush with simultaneous push and take.
    drive(2'b00, 2'b01, 32'h0); cyc();
    check("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1; drive(2'b11, 2'b11, 32'h900); cyc();
    flush = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    drive(2'b00, 2'b00, 32'h0);
    cyc(); cyc();
    check("post_flush_valid", 64'(out_valid), 64'd0);

    // count = 1, take 11 with in_valid 10.
    drive(2'b01, 2'b00, 32'h300); cyc();
    check("one_count", 64'(count), 64'd1);
    drive(2'b10, 2'b11, 32'h400); cyc();
    check("pop1_count", 64'(count), 64'd0);
    check("pop1_valid", 64'(out_valid), 64'd0);

    // Reset mid-stream with five entries held.
    drive(2'b11, 2'b00, 32'h500); cyc();
    drive(2'b11, 2'b00, 32'h508); cyc();
    drive(2'b01, 2'b00, 32'h510); cyc();
    check("pre_rst_count", 64'(count), 64'd5);
    rst_n = 1'b0; drive(2'b11, 2'b11, 32'h600); cyc();
    rst_n = 1'b1;
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_inst0", 64'(out_inst0), 64'd0);
    check("mrst_ready", 64'(in_ready), 64'd1);

    // Randomized phase; fetch holds its inputs while the model says not ready.
    drive(2'b00, 2'b00, 32'h0);
    for (int k = 0; k < 3000; k++) begin
      if (mq.size() <= DEPTH - 2) begin
        in_valid = 2'($urandom_range(0, 3));
        in_inst0 = $urandom; in_inst1 = $urandom;
        in_pc0   = $urandom; in_pc1   = $urandom;
      end
      out_take = 2'($urandom_range(0, 3));
      flush    = ($urandom_range(0, 31) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      cyc();
    end
    rst_n = 1'b1; flush = 1'b0;
    drive(2'b00, 2'b00, 32'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
